axis_lane_packer: RTL and testbench

//  Stream upsizer that directly consumes the output of the AXIS pipeline register.

---
 rtl/axis_pkg.sv | 22 ++
 rtl/axis_lane_packer_if.sv | 20 ++
 rtl/axis_lane_packer.sv | 152 +++++++++++++++
 tb/tb_axis_lane_packer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXIS helpers: default widths and derived-width functions.
// Optional build macro used by the packer: AXIS_PACKER_COUNT_EN.
package axis_pkg;

    localparam int DEF_S_DATA_WIDTH = 32;
    localparam int DEF_RATIO        = 4;
    localparam int DEF_USER_WIDTH   = 1;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

    // Lane index never collapses to zero width, even for a 1:1 packer.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/axis_lane_packer_if.sv
// AXI-Stream bundle (data, keep, valid/ready, last, user) with master/slave views.
interface axis_lane_packer_if
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_S_DATA_WIDTH,
    parameter int USER_WIDTH = DEF_USER_WIDTH
);
    localparam int KEEP_WIDTH = keep_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/axis_lane_packer.sv
// Purpose: packs RATIO narrow beats into one wide beat; tlast flushes a partial group. Macro: AXIS_PACKER_COUNT_EN.
// Latency: closing beat accepted at cycle t -> wide beat valid at t+1; 1 narrow beat/cycle sustained.
// Backpressure: one spare group buffer; s_axis.tready = !asm_full (registered, no path from m_axis.tready).
module axis_lane_packer
    import axis_pkg::*;
#(
    parameter int S_DATA_WIDTH = DEF_S_DATA_WIDTH,
    parameter int RATIO        = DEF_RATIO,
    parameter int USER_WIDTH   = DEF_USER_WIDTH
) (
    input  logic               clk,
    input  logic               rstn,
    axis_lane_packer_if.slave  s_axis,
    axis_lane_packer_if.master m_axis
`ifdef AXIS_PACKER_COUNT_EN
    ,
    output logic [cnt_width(RATIO)-1:0] m_axis_tcount
`endif
);

    localparam int S_KEEP_WIDTH = keep_width(S_DATA_WIDTH);
    localparam int M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
    localparam int M_KEEP_WIDTH = keep_width(M_DATA_WIDTH);
    localparam int IDX_W        = idx_width(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [IDX_W-1:0]        idx;
    logic [M_DATA_WIDTH-1:0] asm_data;
    logic [M_KEEP_WIDTH-1:0] asm_keep;
    logic [USER_WIDTH-1:0]   asm_user;
    logic                    asm_last;
    logic                    asm_full;

    logic [M_DATA_WIDTH-1:0] ins_data;
    logic [M_KEEP_WIDTH-1:0] ins_keep;
    logic [USER_WIDTH-1:0]   ins_user;

    logic [M_DATA_WIDTH-1:0] m_data_q;
    logic [M_KEEP_WIDTH-1:0] m_keep_q;
    logic [USER_WIDTH-1:0]   m_user_q;
    logic                    m_valid_q;
    logic                    m_last_q;

    logic s_fire;
    logic grp_close;
    logic out_free;
    logic m_fire;

    assign s_fire    = s_axis.tvalid & ~asm_full;
    assign grp_close = s_fire & ((idx == LAST_IDX) | s_axis.tlast);
    assign out_free  = ~m_valid_q | m_axis.tready;
    assign m_fire    = m_valid_q & m_axis.tready;

    // Assembly word with the incoming beat dropped into lane idx; lanes past idx read as empty.
    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        localparam logic [IDX_W-1:0] LANE = IDX_W'(i);
        assign ins_data[i*S_DATA_WIDTH +: S_DATA_WIDTH] =
            (LANE == idx) ? s_axis.tdata :
            (LANE <  idx) ? asm_data[i*S_DATA_WIDTH +: S_DATA_WIDTH] : '0;
        assign ins_keep[i*S_KEEP_WIDTH +: S_KEEP_WIDTH] =
            (LANE == idx) ? s_axis.tkeep :
            (LANE <  idx) ? asm_keep[i*S_KEEP_WIDTH +: S_KEEP_WIDTH] : '0;
    end

    assign ins_user = (idx == '0) ? s_axis.tuser : asm_user;

`ifdef AXIS_PACKER_COUNT_EN
    localparam int CNT_W = cnt_width(RATIO);
    logic [CNT_W-1:0] asm_cnt;
    logic [CNT_W-1:0] m_cnt_q;
    logic [CNT_W-1:0] close_cnt;

    assign close_cnt     = CNT_W'(idx) + CNT_W'(1);
    assign m_axis_tcount = m_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            asm_cnt <= '0;
            m_cnt_q <= '0;
        end else if (asm_full && out_free) begin
            m_cnt_q <= asm_cnt;
            asm_cnt <= '0;
        end else if (grp_close) begin
            if (out_free) m_cnt_q <= close_cnt;
            else          asm_cnt <= close_cnt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx       <= '0;
            asm_data  <= '0;
            asm_keep  <= '0;
            asm_user  <= '0;
            asm_last  <= 1'b0;
            asm_full  <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_user_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            if (m_fire) m_valid_q <= 1'b0;

            if (asm_full && out_free) begin
                m_data_q  <= asm_data;
                m_keep_q  <= asm_keep;
                m_user_q  <= asm_user;
                m_last_q  <= asm_last;
                m_valid_q <= 1'b1;
                asm_full  <= 1'b0;
                asm_data  <= '0;
                asm_keep  <= '0;
                asm_user  <= '0;
                asm_last  <= 1'b0;
            end else if (grp_close) begin
                idx <= '0;
                if (out_free) begin
                    m_data_q  <= ins_data;
                    m_keep_q  <= ins_keep;
                    m_user_q  <= ins_user;
                    m_last_q  <= s_axis.tlast;
                    m_valid_q <= 1'b1;
                    asm_data  <= '0;
                    asm_keep  <= '0;
                    asm_user  <= '0;
                end else begin
                    // Output still owned by downstream: park the finished group and stall input.
                    asm_data <= ins_data;
                    asm_keep <= ins_keep;
                    asm_user <= ins_user;
                    asm_last <= s_axis.tlast;
                    asm_full <= 1'b1;
                end
            end else if (s_fire) begin
                idx      <= idx + IDX_W'(1);
                asm_data <= ins_data;
                asm_keep <= ins_keep;
                asm_user <= ins_user;
            end
        end
    end

    assign s_axis.tready = ~asm_full;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tkeep  = m_keep_q;
    assign m_axis.tuser  = m_user_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;

endmodule

// File: tb/tb_axis_lane_packer.sv
// Directed + randomized bench: RATIO=4 packer under test, RATIO=1/2 packers fed its accepted beat stream.
module tb_axis_lane_packer;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        logic         u;
        logic [2:0]   c;
    } word_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    axis_lane_packer_if #(.DATA_WIDTH(32),  .USER_WIDTH(1)) s4 ();
    axis_lane_packer_if #(.DATA_WIDTH(128), .USER_WIDTH(1)) m4 ();
    axis_lane_packer_if #(.DATA_WIDTH(32),  .USER_WIDTH(1)) s1 ();
    axis_lane_packer_if #(.DATA_WIDTH(32),  .USER_WIDTH(1)) m1 ();
    axis_lane_packer_if #(.DATA_WIDTH(32),  .USER_WIDTH(1)) s2 ();
    axis_lane_packer_if #(.DATA_WIDTH(64),  .USER_WIDTH(1)) m2 ();

    logic [2:0] c4w, c1w, c2w;
`ifdef AXIS_PACKER_COUNT_EN
    logic [2:0] cnt4;
    logic [0:0] cnt1;
    logic [1:0] cnt2;
    assign c4w = cnt4;
    assign c1w = 3'(cnt1);
    assign c2w = 3'(cnt2);
`else
    assign c4w = 3'd0;
    assign c1w = 3'd0;
    assign c2w = 3'd0;
`endif

    axis_lane_packer #(.S_DATA_WIDTH(32), .RATIO(4), .USER_WIDTH(1)) dut4 (
        .clk(clk), .rstn(rstn), .s_axis(s4), .m_axis(m4)
`ifdef AXIS_PACKER_COUNT_EN
        , .m_axis_tcount(cnt4)
`endif
    );
    axis_lane_packer #(.S_DATA_WIDTH(32), .RATIO(1), .USER_WIDTH(1)) dut1 (
        .clk(clk), .rstn(rstn), .s_axis(s1), .m_axis(m1)
`ifdef AXIS_PACKER_COUNT_EN
        , .m_axis_tcount(cnt1)
`endif
    );
    axis_lane_packer #(.S_DATA_WIDTH(32), .RATIO(2), .USER_WIDTH(1)) dut2 (
        .clk(clk), .rstn(rstn), .s_axis(s2), .m_axis(m2)
`ifdef AXIS_PACKER_COUNT_EN
        , .m_axis_tcount(cnt2)
`endif
    );

    // Small packers see exactly the beats the RATIO=4 packer accepts.
    assign s1.tvalid = s4.tvalid & s4.tready;
    assign s1.tdata  = s4.tdata;
    assign s1.tkeep  = s4.tkeep;
    assign s1.tlast  = s4.tlast;
    assign s1.tuser  = s4.tuser;
    assign s2.tvalid = s4.tvalid & s4.tready;
    assign s2.tdata  = s4.tdata;
    assign s2.tkeep  = s4.tkeep;
    assign s2.tlast  = s4.tlast;
    assign s2.tuser  = s4.tuser;
    assign m1.tready = 1'b1;
    assign m2.tready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    word_t exp1[$], exp2[$], exp4[$];
    word_t got1[$], got2[$], got4[$];
    int    e1p, e2p, e4p, g1p, g2p, g4p;
    int    acc_cnt  = 0;
    int    drop_cnt = 0;

    logic [127:0] md [3];
    logic [15:0]  mk_ [3];
    logic         mu [3];
    int           ml [3];

    function automatic word_t mk(input logic [127:0] d, input logic [15:0] k,
                                 input logic l, input logic u, input logic [2:0] c);
        word_t w;
        w.d = d; w.k = k; w.l = l; w.u = u; w.c = c;
        return w;
    endfunction

    // Reference packer: shift each accepted beat into the next lane, emit on full group or tlast.
    task automatic model_step(input int r, input logic [31:0] d, input logic [3:0] k,
                              input logic l, input logic u);
        int ratio;
        ratio = 1 << r;
        if (ml[r] == 0) mu[r] = u;
        md[r]  = md[r]  | (128'(d) << (ml[r] * 32));
        mk_[r] = mk_[r] | (16'(k)  << (ml[r] * 4));
        if (ml[r] == ratio - 1 || l) begin
            case (r)
                0:       exp1.push_back(mk(md[r], mk_[r], l, mu[r], 3'(ml[r] + 1)));
                1:       exp2.push_back(mk(md[r], mk_[r], l, mu[r], 3'(ml[r] + 1)));
                default: exp4.push_back(mk(md[r], mk_[r], l, mu[r], 3'(ml[r] + 1)));
            endcase
            md[r] = '0; mk_[r] = '0; mu[r] = 1'b0; ml[r] = 0;
        end else begin
            ml[r] = ml[r] + 1;
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < 3; r++) begin
                md[r] = '0; mk_[r] = '0; mu[r] = 1'b0; ml[r] = 0;
            end
        end else if (s4.tvalid && s4.tready) begin
            acc_cnt++;
            for (int r = 0; r < 3; r++) model_step(r, s4.tdata, s4.tkeep, s4.tlast, s4.tuser[0]);
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (!s4.tready) drop_cnt++;
            if (m4.tvalid && m4.tready)
                got4.push_back(mk(m4.tdata, m4.tkeep, m4.tlast, m4.tuser[0], c4w));
            if (m1.tvalid && m1.tready)
                got1.push_back(mk(128'(m1.tdata), 16'(m1.tkeep), m1.tlast, m1.tuser[0], c1w));
            if (m2.tvalid && m2.tready)
                got2.push_back(mk(128'(m2.tdata), 16'(m2.tkeep), m2.tlast, m2.tuser[0], c2w));
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cmp_q(input string tag, input word_t e[$], input int eb,
                         input word_t g[$], input int gb);
        int ne, ng;
        word_t a, b;
        ne = e.size() - eb;
        ng = g.size() - gb;
        chk({tag, ".count"}, 128'(ng), 128'(ne));
        for (int i = 0; i < ne && i < ng; i++) begin
            a = g[gb + i];
            b = e[eb + i];
            chk($sformatf("%s[%0d].data", tag, i), a.d, b.d);
            chk($sformatf("%s[%0d].keep", tag, i), 128'(a.k), 128'(b.k));
            chk($sformatf("%s[%0d].last", tag, i), 128'(a.l), 128'(b.l));
            chk($sformatf("%s[%0d].user", tag, i), 128'(a.u), 128'(b.u));
`ifdef AXIS_PACKER_COUNT_EN
            chk($sformatf("%s[%0d].count", tag, i), 128'(a.c), 128'(b.c));
`endif
        end
    endtask

    task automatic sync_ptrs();
        e1p = exp1.size(); e2p = exp2.size(); e4p = exp4.size();
        g1p = got1.size(); g2p = got2.size(); g4p = got4.size();
    endtask

    task automatic cmp_small(input string tag);
        cmp_q({tag, ".r1"}, exp1, e1p, got1, g1p);
        cmp_q({tag, ".r2"}, exp2, e2p, got2, g2p);
        sync_ptrs();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        int w;
        s4.tvalid = 1'b1; s4.tdata = d; s4.tkeep = k; s4.tlast = l; s4.tuser = u;
        w = 0;
        @(negedge clk);
        while (!s4.tready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (w >= 100) chk("send.accept_timeout", 128'(s4.tready), 128'd1);
        @(posedge clk);
        #1;
        s4.tvalid = 1'b0; s4.tlast = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t dir[$];
        int    acc_base, drop_base;
        logic  done_b;

        rstn = 1'b0;
        s4.tvalid = 1'b0; s4.tdata = '0; s4.tkeep = '0; s4.tlast = 1'b0; s4.tuser = '0;
        m4.tready = 1'b0;
        e1p = 0; e2p = 0; e4p = 0; g1p = 0; g2p = 0; g4p = 0;
        idle(3);

        // Reset state
        @(negedge clk);
        chk("rst.m_tvalid", 128'(m4.tvalid), 128'd0);
        chk("rst.s_tready", 128'(s4.tready), 128'd1);
        chk("rst.m_tdata",  m4.tdata,        128'd0);
        chk("rst.m_tkeep",  128'(m4.tkeep),  128'd0);
        chk("rst.m_tlast",  128'(m4.tlast),  128'd0);
        chk("rst.m_tuser",  128'(m4.tuser),  128'd0);
`ifdef AXIS_PACKER_COUNT_EN
        chk("rst.m_tcount", 128'(cnt4),      128'd0);
`endif
        @(posedge clk); #1;
        rstn = 1'b1;
        m4.tready = 1'b1;
        sync_ptrs();

        // Two full groups back to back
        drop_base = drop_cnt;
        for (int i = 1; i <= 8; i++) send(32'(i), 4'hF, i == 8, 1'b0);
        idle(4);
        chk("t1.no_stall", 128'(drop_cnt - drop_base), 128'd0);
        dir = {};
        dir.push_back(mk(128'h00000004_00000003_00000002_00000001, 16'hFFFF, 1'b0, 1'b0, 3'd4));
        dir.push_back(mk(128'h00000008_00000007_00000006_00000005, 16'hFFFF, 1'b1, 1'b0, 3'd4));
        cmp_q("t1", dir, 0, got4, g4p);
        cmp_small("t1");

        // tlast flushes a three-lane group
        send(32'hA, 4'hF, 1'b0, 1'b0);
        send(32'hB, 4'hF, 1'b0, 1'b0);
        send(32'hC, 4'hF, 1'b1, 1'b0);
        idle(3);
        dir = {};
        dir.push_back(mk(128'h00000000_0000000C_0000000B_0000000A, 16'h0FFF, 1'b1, 1'b0, 3'd3));
        cmp_q("t2", dir, 0, got4, g4p);
        cmp_small("t2");

        // Downstream stall: one word held, one parked, input stalls after 8 beats
        m4.tready = 1'b0;
        acc_base = acc_cnt;
        fork
            begin
                for (int i = 0; i < 12; i++) send(32'h11 + 32'(i), 4'hF, i == 11, 1'b0);
            end
            begin
                idle(20);
                chk("t3.accepted", 128'(acc_cnt - acc_base), 128'd8);
                chk("t3.s_tready", 128'(s4.tready), 128'd0);
                chk("t3.m_tvalid", 128'(m4.tvalid), 128'd1);
                chk("t3.hold0", m4.tdata, 128'h00000014_00000013_00000012_00000011);
                idle(5);
                chk("t3.hold1", m4.tdata, 128'h00000014_00000013_00000012_00000011);
                chk("t3.hold_keep", 128'(m4.tkeep), 128'hFFFF);
                m4.tready = 1'b1;
            end
        join
        idle(6);
        dir = {};
        dir.push_back(mk(128'h00000014_00000013_00000012_00000011, 16'hFFFF, 1'b0, 1'b0, 3'd4));
        dir.push_back(mk(128'h00000018_00000017_00000016_00000015, 16'hFFFF, 1'b0, 1'b0, 3'd4));
        dir.push_back(mk(128'h0000001C_0000001B_0000001A_00000019, 16'hFFFF, 1'b1, 1'b0, 3'd4));
        cmp_q("t3", dir, 0, got4, g4p);
        cmp_small("t3");

        // Single-beat packet: exactly one cycle from accept to valid
        s4.tvalid = 1'b1; s4.tdata = 32'h55; s4.tkeep = 4'hF; s4.tlast = 1'b1; s4.tuser = 1'b1;
        @(negedge clk);
        chk("t4.pre_vld", 128'(m4.tvalid), 128'd0);
        chk("t4.s_tready", 128'(s4.tready), 128'd1);
        @(posedge clk); #1;
        s4.tvalid = 1'b0; s4.tlast = 1'b0; s4.tuser = 1'b0;
        @(negedge clk);
        chk("t4.m_tvalid", 128'(m4.tvalid), 128'd1);
        chk("t4.m_tdata",  m4.tdata,        128'h55);
        chk("t4.m_tkeep",  128'(m4.tkeep),  128'h000F);
        chk("t4.m_tuser",  128'(m4.tuser),  128'd1);
        chk("t4.m_tlast",  128'(m4.tlast),  128'd1);
`ifdef AXIS_PACKER_COUNT_EN
        chk("t4.m_tcount", 128'(cnt4),      128'd1);
`endif
        @(negedge clk);
        chk("t4.post_vld", 128'(m4.tvalid), 128'd0);
        @(posedge clk); #1;
        cmp_small("t4");

        // Reset in the middle of a group discards it
        send(32'hA1, 4'hF, 1'b0, 1'b0);
        send(32'hA2, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("t5.rst_m_tvalid", 128'(m4.tvalid), 128'd0);
        chk("t5.rst_s_tready", 128'(s4.tready), 128'd1);
        cmp_small("t5pre");
        idle(2);
        rstn = 1'b1;
        for (int i = 1; i <= 4; i++) send(32'(i), 4'hF, 1'b0, 1'b0);
        idle(3);
        dir = {};
        dir.push_back(mk(128'h00000004_00000003_00000002_00000001, 16'hFFFF, 1'b0, 1'b0, 3'd4));
        cmp_q("t5", dir, 0, got4, g4p);
        cmp_small("t5");

        // Random data, both sides ready: no input stalls
        drop_base = drop_cnt;
        for (int i = 0; i < 16; i++)
            send($urandom, 4'($urandom_range(0, 15)), (i == 15) || ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
        idle(4);
        chk("t6a.no_stall", 128'(drop_cnt - drop_base), 128'd0);
        cmp_q("t6a.r4", exp4, e4p, got4, g4p);
        cmp_small("t6a");

        // Random valid gaps and random downstream ready
        done_b = 1'b0;
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send($urandom, 4'($urandom_range(0, 15)), (i == 47) || ($urandom_range(0, 4) == 0),
                         1'($urandom_range(0, 1)));
                end
                done_b = 1'b1;
            end
            begin
                while (!done_b) begin
                    @(posedge clk); #1;
                    m4.tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m4.tready = 1'b1;
        idle(8);
        cmp_q("t6b.r4", exp4, e4p, got4, g4p);
        cmp_small("t6b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
